// File: rtl/mmio_responder_pkg.sv
// Shared constants for the MMIO responder: region codes, register offsets, default width.
package mmio_responder_pkg;

    localparam int unsigned N_DEFAULT = 9;

    typedef enum logic [1:0] {
        REG_RAM = 2'b00,
        REG_LED = 2'b01,
        REG_SW  = 2'b10,
        REG_TMR = 2'b11
    } region_e;

    // Timer register offsets
    localparam logic [1:0] OFF_LOAD  = 2'd0;
    localparam logic [1:0] OFF_CTRL  = 2'd1;
    localparam logic [1:0] OFF_STAT  = 2'd2;
    localparam logic [1:0] OFF_COUNT = 2'd3;

    // Switch port offsets
    localparam logic [1:0] OFF_SW_DATA = 2'd0;
    localparam logic [1:0] OFF_SW_STAT = 2'd1;

endpackage

// File: rtl/mmio_responder_if.sv
// Processor-side MMIO bus: address, write data, write strobe, read data.
interface mmio_responder_if #(
    parameter int unsigned n = mmio_responder_pkg::N_DEFAULT
);
    logic [n-1:0] ADDR;
    logic [n-1:0] DOUT;
    logic         W;
    logic [n-1:0] DIN;

    modport master (output ADDR, output DOUT, output W, input  DIN);
    modport slave  (input  ADDR, input  DOUT, input  W, output DIN);
endinterface

// File: rtl/mmio_timer.sv
// Prescaled down-counter timer with optional auto-reload and sticky W1C expiry flag.
module mmio_timer
    import mmio_responder_pkg::*;
#(
    parameter int unsigned n        = N_DEFAULT,
    parameter int unsigned PRESCALE = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load_we_i,
    input  logic         ctrl_we_i,
    input  logic         stat_we_i,
    input  logic [n-1:0] wdata_i,
    output logic [n-1:0] load_val_o,
    output logic [n-1:0] count_o,
    output logic [1:0]   ctrl_o,
    output logic         expired_o
);

    localparam int unsigned PW = 8;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    logic [n-1:0]  load_val_q, load_val_d;
    logic [n-1:0]  count_q, count_d;
    logic [PW-1:0] ps_q, ps_d;
    logic [1:0]    ctrl_q, ctrl_d;
    logic          expired_q, expired_d;
    logic          running, tick, expire_set;

    // Next-state: prescaler, tick handling, then register writes (LOAD overrides a tick)
    always_comb begin
        load_val_d = load_val_q;
        count_d    = count_q;
        ps_d       = ps_q;
        ctrl_d     = ctrl_q;
        expired_d  = expired_q;
        expire_set = 1'b0;

        running = ctrl_q[0] && (count_q != '0);
        tick    = running && (ps_q == PS_LAST);

        if (running) begin
            ps_d = tick ? '0 : ps_q + PW'(1);
        end

        if (tick) begin
            if (count_q == n'(1)) begin
                expire_set = 1'b1;
                count_d    = ctrl_q[1] ? load_val_q : '0;
            end else begin
                count_d = count_q - n'(1);
            end
        end

        if (load_we_i) begin
            load_val_d = wdata_i;
            count_d    = wdata_i;
            ps_d       = '0;
            expire_set = 1'b0;
        end

        if (ctrl_we_i) begin
            ctrl_d = wdata_i[1:0];
        end

        if (stat_we_i && wdata_i[0]) begin
            expired_d = 1'b0;
        end
        if (expire_set) begin
            expired_d = 1'b1;
        end
    end

    // Timer state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            load_val_q <= '0;
            count_q    <= '0;
            ps_q       <= '0;
            ctrl_q     <= '0;
            expired_q  <= 1'b0;
        end else begin
            load_val_q <= load_val_d;
            count_q    <= count_d;
            ps_q       <= ps_d;
            ctrl_q     <= ctrl_d;
            expired_q  <= expired_d;
        end
    end

    assign load_val_o = load_val_q;
    assign count_o    = count_q;
    assign ctrl_o     = ctrl_q;
    assign expired_o  = expired_q;

endmodule

// File: rtl/mmio_responder.sv
// MMIO responder: region decode, LED register, synchronised switch port, timer, 1-cycle read mux.
module mmio_responder
    import mmio_responder_pkg::*;
#(
    parameter int unsigned n        = N_DEFAULT,
    parameter int unsigned PRESCALE = 4
) (
    input  logic            clk,
    input  logic            resetn,
    mmio_responder_if.slave bus,
    input  logic [n-1:0]    SW_IN,
    input  logic [n-1:0]    RAM_Q,
    output logic            RAM_WE,
    output logic [n-1:0]    LED
);

    region_e      wr_region;
    logic [1:0]   wr_off;
    logic         tmr_wr;

    logic [n-1:0] led_q, led_d;
    logic [n-1:0] sw_meta_q, sw_sync_q, sw_prev_q;
    logic         sw_changed_q, sw_changed_d;

    // rd_valid_q is cleared by reset so the read mux returns 0 until the first edge
    region_e      rd_region_q;
    logic [1:0]   rd_off_q;
    logic         rd_valid_q;

    logic [n-1:0] tmr_load_val, tmr_count;
    logic [1:0]   tmr_ctrl;
    logic         tmr_expired;
    logic [n-1:0] din_c;
    logic         unused_addr;

    assign wr_region   = region_e'(bus.ADDR[8:7]);
    assign wr_off      = bus.ADDR[1:0];
    assign tmr_wr      = bus.W && (wr_region == REG_TMR);
    assign RAM_WE      = bus.W && (wr_region == REG_RAM);
    assign unused_addr = ^bus.ADDR;

    // Next-state for LED and the switch-change flag (set beats W1C clear)
    always_comb begin
        led_d        = led_q;
        sw_changed_d = sw_changed_q;
        if (bus.W && (wr_region == REG_LED)) begin
            led_d = bus.DOUT;
        end
        if (bus.W && (wr_region == REG_SW) && (wr_off == OFF_SW_STAT) && bus.DOUT[0]) begin
            sw_changed_d = 1'b0;
        end
        if (sw_sync_q != sw_prev_q) begin
            sw_changed_d = 1'b1;
        end
    end

    // Top-level registers: LED, switch synchroniser chain, registered read select
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_q        <= '0;
            sw_meta_q    <= '0;
            sw_sync_q    <= '0;
            sw_prev_q    <= '0;
            sw_changed_q <= 1'b0;
            rd_region_q  <= REG_RAM;
            rd_off_q     <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            led_q        <= led_d;
            sw_meta_q    <= SW_IN;
            sw_sync_q    <= sw_meta_q;
            sw_prev_q    <= sw_sync_q;
            sw_changed_q <= sw_changed_d;
            rd_region_q  <= wr_region;
            rd_off_q     <= wr_off;
            rd_valid_q   <= 1'b1;
        end
    end

    mmio_timer #(
        .n        (n),
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .load_we_i  (tmr_wr && (wr_off == OFF_LOAD)),
        .ctrl_we_i  (tmr_wr && (wr_off == OFF_CTRL)),
        .stat_we_i  (tmr_wr && (wr_off == OFF_STAT)),
        .wdata_i    (bus.DOUT),
        .load_val_o (tmr_load_val),
        .count_o    (tmr_count),
        .ctrl_o     (tmr_ctrl),
        .expired_o  (tmr_expired)
    );

    // Read mux driven by last cycle's region/offset, aligned with RAM_Q
    always_comb begin
        din_c = '0;
        if (rd_valid_q) begin
            unique case (rd_region_q)
                REG_RAM: din_c = RAM_Q;
                REG_LED: din_c = led_q;
                REG_SW: begin
                    case (rd_off_q)
                        OFF_SW_DATA: din_c = sw_sync_q;
                        OFF_SW_STAT: din_c = n'(sw_changed_q);
                        default:     din_c = '0;
                    endcase
                end
                REG_TMR: begin
                    case (rd_off_q)
                        OFF_LOAD:  din_c = tmr_load_val;
                        OFF_CTRL:  din_c = n'(tmr_ctrl);
                        OFF_STAT:  din_c = n'(tmr_expired);
                        default:   din_c = tmr_count;
                    endcase
                end
                default: din_c = '0;
            endcase
        end
    end

    assign bus.DIN = din_c;
    assign LED     = led_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Randomised + directed bench for mmio_responder against a cycle-level behavioural model.
module tb_mmio_responder;
    import mmio_responder_pkg::*;

    localparam int unsigned NW = 9;
    localparam int          PS = 4;

    logic          clk    = 1'b0;
    logic          resetn = 1'b0;
    logic [NW-1:0] SW_IN  = '0;
    logic [NW-1:0] RAM_Q  = '0;
    logic [NW-1:0] LED;
    logic          RAM_WE;

    mmio_responder_if #(.n(NW)) bus ();

    mmio_responder #(.n(NW), .PRESCALE(PS)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave),
        .SW_IN  (SW_IN),
        .RAM_Q  (RAM_Q),
        .RAM_WE (RAM_WE),
        .LED    (LED)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [NW-1:0] mem [0:511];
    logic [NW-1:0] m_ram_rd;
    logic [NW-1:0] m_led;
    logic [NW-1:0] m_hist [0:2];   // SW_IN samples, newest first
    bit            m_chg;
    logic [NW-1:0] m_load, m_cnt;
    int            m_ph;
    bit            m_en, m_auto, m_exp;

    task automatic check_eq(input string tag, input logic [NW-1:0] got, input logic [NW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_led  = '0;
        m_chg  = 1'b0;
        m_load = '0;
        m_cnt  = '0;
        m_ph   = 0;
        m_en   = 1'b0;
        m_auto = 1'b0;
        m_exp  = 1'b0;
        for (int i = 0; i < 3; i++) m_hist[i] = '0;
    endfunction

    // One rising edge of the system given this cycle's bus inputs
    function automatic void m_step(input logic [NW-1:0] a, input logic [NW-1:0] d,
                                   input bit w, input logic [NW-1:0] sw);
        logic [1:0] rg  = a[8:7];
        logic [1:0] off = a[1:0];
        bit tick = 1'b0;
        bit fire = 1'b0;
        bit sw_set;

        m_ram_rd = mem[a];
        if (w && rg == 2'd0) mem[a] = d;
        if (w && rg == 2'd1) m_led = d;

        // sw_sync is the sample from two edges ago, sw_prev from three
        sw_set = (m_hist[1] != m_hist[2]);
        if (w && rg == 2'd2 && off == 2'd1 && d[0]) m_chg = 1'b0;
        if (sw_set) m_chg = 1'b1;
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = sw;

        if (m_en && m_cnt != '0) begin
            m_ph++;
            if (m_ph == PS) begin
                m_ph = 0;
                tick = 1'b1;
            end
        end
        if (tick) begin
            if (m_cnt == NW'(1)) begin
                fire  = 1'b1;
                m_cnt = m_auto ? m_load : '0;
            end else begin
                m_cnt = m_cnt - NW'(1);
            end
        end
        if (w && rg == 2'd3) begin
            if (off == 2'd0) begin
                m_load = d;
                m_cnt  = d;
                m_ph   = 0;
                fire   = 1'b0;
            end
            if (off == 2'd1) begin
                m_en   = d[0];
                m_auto = d[1];
            end
            if (off == 2'd2 && d[0]) m_exp = 1'b0;
        end
        if (fire) m_exp = 1'b1;
    endfunction

    function automatic logic [NW-1:0] m_read(input logic [NW-1:0] a);
        logic [NW-1:0] r = '0;
        case (a[8:7])
            2'd0: r = m_ram_rd;
            2'd1: r = m_led;
            2'd2: begin
                if (a[1:0] == 2'd0) r = m_hist[1];
                else if (a[1:0] == 2'd1) r = NW'(m_chg);
            end
            default: begin
                case (a[1:0])
                    2'd0:    r = m_load;
                    2'd1:    r = NW'({m_auto, m_en});
                    2'd2:    r = NW'(m_exp);
                    default: r = m_cnt;
                endcase
            end
        endcase
        return r;
    endfunction

    // One bus cycle: drive after negedge, check RAM_WE, clock, check DIN/LED on the next negedge
    task automatic cycle(input logic [NW-1:0] a, input logic [NW-1:0] d, input bit w);
        bus.ADDR = a;
        bus.DOUT = d;
        bus.W    = w;
        #1;
        check_eq("ram_we", NW'(RAM_WE), NW'(w && a[8:7] == 2'b00));
        @(posedge clk);
        RAM_Q = mem[a];
        m_step(a, d, w, SW_IN);
        @(negedge clk);
        check_eq("din", bus.DIN, m_read(a));
        check_eq("led", LED, m_led);
    endtask

    task automatic pulse_reset(input int hold);
        resetn = 1'b0;
        #1;
        m_reset();
        check_eq("rst_din", bus.DIN, 9'd0);
        check_eq("rst_led", LED, 9'd0);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        check_eq("rst_din_hold", bus.DIN, 9'd0);
        resetn = 1'b1;
    endtask

    task automatic tmr_arm(input logic [NW-1:0] load, input logic [NW-1:0] ctrl);
        cycle(9'h181, 9'd0, 1'b1);
        cycle(9'h182, 9'd1, 1'b1);
        cycle(9'h180, load, 1'b1);
        cycle(9'h181, ctrl, 1'b1);
    endtask

    initial begin
        logic [NW-1:0] a, d;
        bit w;

        for (int i = 0; i < 512; i++) mem[i] = NW'($urandom);
        m_reset();
        bus.ADDR = '0;
        bus.DOUT = '0;
        bus.W    = 1'b0;
        @(negedge clk);
        pulse_reset(2);

        // LED write and read-back
        cycle(9'h080, 9'h0A5, 1'b1);
        check_eq("led_a5", LED, 9'h0A5);
        cycle(9'h080, 9'd0, 1'b0);
        check_eq("led_read", bus.DIN, 9'h0A5);

        // RAM write then aligned read
        cycle(9'h005, 9'h1C3, 1'b1);
        cycle(9'h005, 9'd0, 1'b0);
        check_eq("ram_read", bus.DIN, 9'h1C3);

        // Switch synchroniser and W1C change flag
        SW_IN = 9'h003;
        for (int i = 1; i <= 3; i++) cycle(9'h100, 9'd0, 1'b0);
        check_eq("sw_data", bus.DIN, 9'h003);
        cycle(9'h101, 9'd0, 1'b0);
        check_eq("sw_chg_set", bus.DIN, 9'd1);
        cycle(9'h101, 9'd1, 1'b1);
        cycle(9'h101, 9'd0, 1'b0);
        check_eq("sw_chg_clr", bus.DIN, 9'd0);

        // One-shot expiry 12 cycles after enable
        tmr_arm(9'd3, 9'd1);
        for (int i = 1; i <= 12; i++) begin
            cycle(9'h182, 9'd0, 1'b0);
            if (i == 11) check_eq("exp_before_12", bus.DIN, 9'd0);
            if (i == 12) check_eq("exp_at_12", bus.DIN, 9'd1);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(9'h183, 9'd0, 1'b0);
            check_eq("count_idle", bus.DIN, 9'd0);
        end

        // Auto-reload
        tmr_arm(9'd3, 9'd3);
        for (int i = 1; i <= 24; i++) begin
            cycle(9'h183, 9'd0, 1'b0);
            if (i == 11) check_eq("auto_cnt_1", bus.DIN, 9'd1);
            if (i == 12 || i == 24) check_eq("auto_reload", bus.DIN, 9'd3);
        end
        cycle(9'h182, 9'd0, 1'b0);
        check_eq("auto_exp", bus.DIN, 9'd1);

        // W1C of STAT on the expiry edge: set wins
        tmr_arm(9'd2, 9'd1);
        for (int i = 1; i <= 7; i++) cycle(9'h182, 9'd0, 1'b0);
        cycle(9'h182, 9'd1, 1'b1);
        check_eq("w1c_vs_set", bus.DIN, 9'd1);
        cycle(9'h182, 9'd0, 1'b0);
        check_eq("w1c_vs_set_hold", bus.DIN, 9'd1);

        // LOAD on a tick edge: load wins
        tmr_arm(9'd3, 9'd1);
        for (int i = 1; i <= 3; i++) cycle(9'h183, 9'd0, 1'b0);
        cycle(9'h180, 9'd7, 1'b1);
        cycle(9'h183, 9'd0, 1'b0);
        check_eq("load_vs_tick", bus.DIN, 9'd7);

        // Reset mid-count
        cycle(9'h080, 9'h155, 1'b1);
        tmr_arm(9'd3, 9'd1);
        for (int i = 0; i < 4; i++) cycle(9'h183, 9'd0, 1'b0);
        check_eq("cnt_before_rst", bus.DIN, 9'd2);
        pulse_reset(1);
        cycle(9'h180, 9'd0, 1'b0); check_eq("rst_load", bus.DIN, 9'd0);
        cycle(9'h181, 9'd0, 1'b0); check_eq("rst_ctrl", bus.DIN, 9'd0);
        cycle(9'h183, 9'd0, 1'b0); check_eq("rst_count", bus.DIN, 9'd0);
        cycle(9'h080, 9'd0, 1'b0); check_eq("rst_led_rd", bus.DIN, 9'd0);
        for (int i = 0; i < 30; i++) begin
            cycle(9'h182, 9'd0, 1'b0);
            check_eq("rst_no_exp", bus.DIN, 9'd0);
        end

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            a = {2'($urandom), 5'($urandom), 2'($urandom)};
            w = ($urandom_range(0, 2) == 0);
            d = NW'($urandom);
            if (a[8:7] == 2'd3 && a[1:0] == 2'd0) d = NW'($urandom_range(0, 6));
            if ($urandom_range(0, 7) == 0) SW_IN = NW'($urandom);
            if ($urandom_range(0, 399) == 0) pulse_reset(int'($urandom_range(0, 2)));
            cycle(a, d, w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_responder.md
MMIO_RESPONDER -- requirements
Module: mmio_responder

Interface
REQ-001 Parameter n, default 9: bus data/address width.
REQ-002 Parameter PRESCALE, default 4: clk cycles per timer tick; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 resetn  input  1  asynchronous active-low reset.
REQ-005 ADDR  input  n  processor address; ADDR[8:7] selects the region, ADDR[1:0] selects the register offset.
REQ-006 DOUT  input  n  processor write data.
REQ-007 W  input  1  processor write strobe, sampled on the clk edge.
REQ-008 SW_IN  input  n  raw asynchronous switch inputs.
REQ-009 RAM_Q  input  n  synchronous memory read data, valid 1 cycle after the address.
REQ-010 RAM_WE  output  n/a (1 bit)  memory write enable; equals W AND region 00; combinational.
REQ-011 DIN  output  n  read data returned to the processor.
REQ-012 LED  output  n  LED register contents.

Function
REQ-013 Region decode SHALL be: 00 = RAM, 01 = LED, 10 = switch port, 11 = timer.
REQ-014 Reads SHALL have 1-cycle latency for every region; region and offset SHALL be registered so that DIN in cycle t+1 reflects ADDR in cycle t, aligned with RAM_Q.
REQ-015 Reads SHALL have no side effects.
REQ-016 Unmapped offsets SHALL read 0, and writes to them SHALL be ignored.
REQ-017 LED region, any offset: W loads LED from DOUT; a read returns LED.
REQ-018 Switch path: SW_IN SHALL pass a 2-flop synchronizer to produce sw_sync; sw_prev SHALL hold the previous sw_sync.
REQ-019 Switch offset 0 SHALL read sw_sync.
REQ-020 Switch offset 1 SHALL read {0, sw_changed}; sw_changed sets when sw_sync != sw_prev.
REQ-021 Writing offset 1 with DOUT[0]=1 SHALL clear sw_changed (W1C); if set and clear occur in the same cycle, set SHALL win.
REQ-022 Timer offset 0 (LOAD), write: load_val <= DOUT, count <= DOUT, prescaler <= 0. Read returns load_val.
REQ-023 Timer offset 1 (CTRL): bit0 = enable, bit1 = auto_reload; read/write.
REQ-024 Timer offset 2 (STAT): bit0 = expired; sticky; W1C; set SHALL win over a simultaneous clear.
REQ-025 Timer offset 3 (COUNT): read-only current count.
REQ-026 Prescaler SHALL run only while enable=1 and count!=0, and SHALL wrap from PRESCALE-1 to 0, producing one tick at the wrap.
REQ-027 Timer tick behaviour:
- count>1: count decrements by 1.
- count==1: expired <= 1; count <= auto_reload ? load_val : 0.
REQ-028 The timer SHALL idle when count==0, including when load_val==0 with auto_reload=1; no expiry is generated in that state.
REQ-029 A LOAD write in the same cycle as a tick SHALL win; that tick is discarded.
REQ-030 Clearing enable SHALL freeze count and the prescaler.
REQ-031 Setting enable again SHALL resume counting from the frozen values.

Reset
REQ-032 On resetn=0, the following SHALL clear to 0 immediately, independent of clk: LED, load_val, count, prescaler, CTRL, expired, sw_changed, sync flops, sw_prev, registered region/offset.
REQ-033 While resetn=0, DIN SHALL be 0 (registered region forced to a zero-reading state).
REQ-034 Reset asserted mid-count SHALL abort the count, with no expiry generated.
REQ-035 After resetn rises, sw_changed SHALL remain 0 until sw_sync differs from sw_prev.

Structure
REQ-036 A shared package SHALL hold the region codes (RAM/LED/SW/TMR), the offset constants (LOAD/CTRL/STAT/COUNT, SW_DATA/SW_STAT) and the data width default.
REQ-037 The timer SHALL be one sub-module, mmio_timer, containing load_val, count, prescaler, CTRL and expired.
REQ-038 The decode, LED register, switch port and read mux SHALL remain in the top level.

Verification
REQ-039 Write DOUT=9'h0A5 to ADDR=9'h080 with W=1 -> LED=9'h0A5 after that edge, RAM_WE=0; a read of 9'h080 gives DIN=9'h0A5 one cycle later.
REQ-040 Write to ADDR=9'h005 with W=1 -> RAM_WE=1 in that cycle; the next-cycle DIN equals RAM_Q.
REQ-041 SW_IN 0 -> 9'h003 -> read of 9'h100 returns 9'h003 after 2-3 edges, and 9'h101 reads 1; write 1 to 9'h101 -> reads 0.
REQ-042 PRESCALE=4: LOAD=3, CTRL=1 -> expired=1 exactly 12 cycles after enable, COUNT=0 and stays 0; with CTRL=3 instead, COUNT reloads to 3 and expired sets every 12 cycles.
REQ-043 W1C of STAT coinciding with an expiry edge -> expired stays 1; a LOAD write coinciding with a tick -> COUNT equals the new load value.
REQ-044 resetn pulsed low mid-count with COUNT=2 -> all registers read 0, LED=0, and no expiry afterward.
